// File: rtl/alu_operand_sel_buf.sv
// alu_operand_sel_buf
// Registered operand selector for the ALU B input. One of N_SRC sources or a
// built-in constant is chosen by sel and captured into a 2-entry elastic
// buffer with valid/ready handshakes on both sides. Illegal selects replay the
// last operand pushed with a legal select and raise a sticky error flag.
module alu_operand_sel_buf #(
    parameter int              WIDTH     = 32,
    parameter int              N_SRC     = 5,
    parameter int              SEL_W     = 3,
    parameter int              CONST_SRC = 1,
    parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(32'd4)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_SRC*WIDTH-1:0] src_flat,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sel_err,
    input  logic                   err_clr
);

    // Number of held entries; the head entry is the registered output itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // One extra bit so N_SRC == 2**SEL_W is representable.
    localparam logic [SEL_W:0]   N_SRC_L   = (SEL_W+1)'(N_SRC);
    localparam logic [SEL_W-1:0] CONST_SEL = SEL_W'(CONST_SRC);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_nxt_s;
    logic [WIDTH-1:0] tail_r;
    logic [WIDTH-1:0] tail_nxt_s;
    logic [WIDTH-1:0] last_legal_r;
    logic [WIDTH-1:0] last_legal_nxt_s;
    logic             out_valid_r;
    logic             sel_err_r;
    logic             sel_err_nxt_s;

    logic             legal_s;
    logic [WIDTH-1:0] src_pick_s;
    logic [WIDTH-1:0] op_val_s;
    logic             in_ready_s;
    logic             push_s;
    logic             pop_s;

    assign legal_s    = ({1'b0, sel} < N_SRC_L);
    assign in_ready_s = (state_r != ST_TWO);
    assign push_s     = in_valid & in_ready_s;
    assign pop_s      = out_valid_r & out_ready;

    // Extract the addressed source slice; only meaningful for legal selects.
    always_comb begin
        src_pick_s = {WIDTH{1'b0}};
        for (int k = 0; k < N_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                src_pick_s = src_flat[k*WIDTH +: WIDTH];
            end else begin
                src_pick_s = src_pick_s;
            end
        end
    end

    // Resolve the operand: constant, legal source, or replay of the last legal operand.
    always_comb begin
        op_val_s = last_legal_r;
        if (sel == CONST_SEL) begin
            op_val_s = CONST_VAL;
        end else if (legal_s) begin
            op_val_s = src_pick_s;
        end else begin
            op_val_s = last_legal_r;
        end
    end

    // Buffer occupancy transitions and head/tail next values.
    always_comb begin
        state_nxt_s = state_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        case (state_r)
            ST_EMPTY: begin
                if (push_s) begin
                    state_nxt_s = ST_ONE;
                    head_nxt_s  = op_val_s;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (push_s && pop_s) begin
                    state_nxt_s = ST_ONE;
                    head_nxt_s  = op_val_s;
                end else if (push_s) begin
                    state_nxt_s = ST_TWO;
                    tail_nxt_s  = op_val_s;
                end else if (pop_s) begin
                    // Head keeps its stale value; only out_valid drops.
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_ONE;
                end
            end
            ST_TWO: begin
                if (pop_s) begin
                    state_nxt_s = ST_ONE;
                    head_nxt_s  = tail_r;
                end else begin
                    state_nxt_s = ST_TWO;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // Sticky error and replay register change only on accepted pushes (clear aside).
    always_comb begin
        sel_err_nxt_s    = sel_err_r;
        last_legal_nxt_s = last_legal_r;
        if (push_s && !legal_s) begin
            sel_err_nxt_s = 1'b1;
        end else if (err_clr) begin
            sel_err_nxt_s = 1'b0;
        end else begin
            sel_err_nxt_s = sel_err_r;
        end
        if (push_s && legal_s) begin
            last_legal_nxt_s = op_val_s;
        end else begin
            last_legal_nxt_s = last_legal_r;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and flag registers; reset discards any buffered operands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r       <= {WIDTH{1'b0}};
            tail_r       <= {WIDTH{1'b0}};
            last_legal_r <= {WIDTH{1'b0}};
            out_valid_r  <= 1'b0;
            sel_err_r    <= 1'b0;
        end else begin
            head_r       <= head_nxt_s;
            tail_r       <= tail_nxt_s;
            last_legal_r <= last_legal_nxt_s;
            out_valid_r  <= (state_nxt_s != ST_EMPTY);
            sel_err_r    <= sel_err_nxt_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out       = head_r;
    assign out_valid = out_valid_r;
    assign sel_err   = sel_err_r;

endmodule
